// File: rtl/mdio_slave_rx.sv
// Clause-22 MDIO frame slave: preamble hunt, ST/OP/PHYAD/REGAD decode,
// register write strobe or read fetch with serialised turnaround and data.
module mdio_slave_rx #(
  parameter logic [4:0] PHY_ADDR  = 5'd1,
  parameter int         NUM_PORTS = 1,
  parameter int         PRE_LEN   = 32,
  parameter bit         BCAST_EN  = 1'b0,
  localparam int        PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic          mdc,
  input  logic          reset,
  input  logic          mdio_in,
  output logic          mdio_out,
  output logic          mdio_oe,
  output logic [PW-1:0] port,
  output logic [4:0]    addr,
  output logic [15:0]   wr_data,
  output logic          wr_stb,
  output logic          rd_stb,
  input  logic [15:0]   rd_data,
  output logic          mdio_done,
  output logic          frame_err
);

  localparam int             CW      = $clog2(PRE_LEN + 1);
  localparam logic [CW-1:0]  PRE_MAX = CW'(PRE_LEN);
  localparam logic [5:0]     ADDR_LO = {1'b0, PHY_ADDR};
  localparam logic [5:0]     ADDR_HI = 6'(int'(PHY_ADDR) + NUM_PORTS - 1);

  typedef enum logic [2:0] {
    S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      k_q, k_d;
  logic [CW-1:0]   pre_cnt_q, pre_cnt_d;
  logic            op_hi_q, op_hi_d;
  logic            rd_q, rd_d;
  logic [4:0]      addr_sh_q, addr_sh_d;
  logic [PW-1:0]   port_pend_q, port_pend_d;
  logic [PW-1:0]   port_q, port_d;
  logic [4:0]      addr_q, addr_d;
  logic [15:0]     data_sh_q, data_sh_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            wr_stb_q, wr_stb_d;
  logic            rd_stb_q, rd_stb_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            out_q, out_d;
  logic            oe_q, oe_d;

  logic [4:0]      phyad_w;
  logic            in_range_w;
  logic            bcast_w;
  logic            accept_w;

  always_comb begin
    phyad_w    = {addr_sh_q[3:0], mdio_in};
    in_range_w = ({1'b0, phyad_w} >= ADDR_LO) && ({1'b0, phyad_w} <= ADDR_HI);
    // With broadcast enabled, PHYAD 0 is reserved for broadcast writes only.
    bcast_w    = BCAST_EN && (phyad_w == 5'd0) && !rd_q;
    accept_w   = bcast_w ||
                 (in_range_w && !(BCAST_EN && (phyad_w == 5'd0) && rd_q));
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q + 5'd1;
    pre_cnt_d   = pre_cnt_q;
    op_hi_d     = op_hi_q;
    rd_d        = rd_q;
    addr_sh_d   = addr_sh_q;
    port_pend_d = port_pend_q;
    port_d      = port_q;
    addr_d      = addr_q;
    data_sh_d   = data_sh_q;
    wr_data_d   = wr_data_q;
    wr_stb_d    = 1'b0;
    rd_stb_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    out_d       = out_q;
    oe_d        = oe_q;

    case (state_q)
      S_PRE: begin
        k_d = 5'd0;
        if (mdio_in) begin
          if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 1'b1;
        end else if (pre_cnt_q == PRE_MAX) begin
          // This 0 is ST bit 0; the next sampled bit is k=1.
          state_d   = S_ST;
          k_d       = 5'd1;
          pre_cnt_d = '0;
        end else begin
          pre_cnt_d = '0;
        end
      end

      S_ST: begin
        if (mdio_in) begin
          state_d = S_OP;
        end else begin
          err_d     = 1'b1;
          state_d   = S_PRE;
          pre_cnt_d = '0;
        end
      end

      S_OP: begin
        if (k_q == 5'd2) begin
          op_hi_d = mdio_in;
        end else if (op_hi_q != mdio_in) begin
          rd_d    = op_hi_q;
          state_d = S_PHYAD;
        end else begin
          err_d     = 1'b1;
          state_d   = S_PRE;
          pre_cnt_d = '0;
        end
      end

      S_PHYAD: begin
        addr_sh_d = phyad_w;
        if (k_q == 5'd8) begin
          if (accept_w) begin
            state_d     = S_REGAD;
            port_pend_d = bcast_w ? '0 : PW'(phyad_w - PHY_ADDR);
          end else begin
            state_d = S_SKIP;
          end
        end
      end

      S_REGAD: begin
        addr_sh_d = phyad_w;
        if (k_q == 5'd13) begin
          addr_d   = phyad_w;
          port_d   = port_pend_q;
          rd_stb_d = rd_q;
          state_d  = S_TA;
        end
      end

      S_TA: begin
        if (k_q == 5'd14) begin
          if (rd_q) begin
            data_sh_d = rd_data;
            oe_d      = 1'b1;
            out_d     = 1'b0;
          end
        end else begin
          if (rd_q) begin
            out_d     = data_sh_q[15];
            data_sh_d = {data_sh_q[14:0], 1'b0};
          end
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (rd_q) begin
          out_d     = data_sh_q[15];
          data_sh_d = {data_sh_q[14:0], 1'b0};
        end else begin
          data_sh_d = {data_sh_q[14:0], mdio_in};
        end
        if (k_q == 5'd31) begin
          if (rd_q) begin
            oe_d  = 1'b0;
            out_d = 1'b0;
          end else begin
            wr_data_d = {data_sh_q[14:0], mdio_in};
            wr_stb_d  = 1'b1;
          end
          done_d    = 1'b1;
          state_d   = S_PRE;
          pre_cnt_d = '0;
        end
      end

      S_SKIP: begin
        if (k_q == 5'd31) begin
          state_d   = S_PRE;
          pre_cnt_d = '0;
        end
      end

      default: begin
        state_d   = S_PRE;
        pre_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge mdc or posedge reset) begin
    if (reset) begin
      state_q     <= S_PRE;
      k_q         <= '0;
      pre_cnt_q   <= '0;
      op_hi_q     <= 1'b0;
      rd_q        <= 1'b0;
      addr_sh_q   <= '0;
      port_pend_q <= '0;
      port_q      <= '0;
      addr_q      <= '0;
      data_sh_q   <= '0;
      wr_data_q   <= '0;
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_q       <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      pre_cnt_q   <= pre_cnt_d;
      op_hi_q     <= op_hi_d;
      rd_q        <= rd_d;
      addr_sh_q   <= addr_sh_d;
      port_pend_q <= port_pend_d;
      port_q      <= port_d;
      addr_q      <= addr_d;
      data_sh_q   <= data_sh_d;
      wr_data_q   <= wr_data_d;
      wr_stb_q    <= wr_stb_d;
      rd_stb_q    <= rd_stb_d;
      done_q      <= done_d;
      err_q       <= err_d;
      out_q       <= out_d;
      oe_q        <= oe_d;
    end
  end

  assign mdio_out  = out_q;
  assign mdio_oe   = oe_q;
  assign port      = port_q;
  assign addr      = addr_q;
  assign wr_data   = wr_data_q;
  assign wr_stb    = wr_stb_q;
  assign rd_stb    = rd_stb_q;
  assign mdio_done = done_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_mdio_slave_rx.sv
// Directed bench for mdio_slave_rx: three configurations share one MDIO
// stimulus stream; per-bit samples of each instance are checked per scenario.
module tb_mdio_slave_rx;

  logic        mdc = 1'b0;
  logic        reset = 1'b1;
  logic        mdio_in = 1'b1;
  logic [15:0] rd_data = 16'hA5C3;

  always #5 mdc = ~mdc;

  logic        u0_out, u0_oe, u0_wr_stb, u0_rd_stb, u0_done, u0_err;
  logic [0:0]  u0_port;
  logic [4:0]  u0_addr;
  logic [15:0] u0_wr_data;
  logic        u1_out, u1_oe, u1_wr_stb, u1_rd_stb, u1_done, u1_err;
  logic [1:0]  u1_port;
  logic [4:0]  u1_addr;
  logic [15:0] u1_wr_data;
  logic        u2_out, u2_oe, u2_wr_stb, u2_rd_stb, u2_done, u2_err;
  logic [0:0]  u2_port;
  logic [4:0]  u2_addr;
  logic [15:0] u2_wr_data;

  mdio_slave_rx u0 (
    .mdc(mdc), .reset(reset), .mdio_in(mdio_in), .mdio_out(u0_out), .mdio_oe(u0_oe),
    .port(u0_port), .addr(u0_addr), .wr_data(u0_wr_data), .wr_stb(u0_wr_stb),
    .rd_stb(u0_rd_stb), .rd_data(rd_data), .mdio_done(u0_done), .frame_err(u0_err)
  );

  mdio_slave_rx #(.PHY_ADDR(5'd8), .NUM_PORTS(4)) u1 (
    .mdc(mdc), .reset(reset), .mdio_in(mdio_in), .mdio_out(u1_out), .mdio_oe(u1_oe),
    .port(u1_port), .addr(u1_addr), .wr_data(u1_wr_data), .wr_stb(u1_wr_stb),
    .rd_stb(u1_rd_stb), .rd_data(rd_data), .mdio_done(u1_done), .frame_err(u1_err)
  );

  mdio_slave_rx #(.BCAST_EN(1'b1)) u2 (
    .mdc(mdc), .reset(reset), .mdio_in(mdio_in), .mdio_out(u2_out), .mdio_oe(u2_oe),
    .port(u2_port), .addr(u2_addr), .wr_data(u2_wr_data), .wr_stb(u2_wr_stb),
    .rd_stb(u2_rd_stb), .rd_data(rd_data), .mdio_done(u2_done), .frame_err(u2_err)
  );

  // Per-bit samples: {rd_stb, wr_stb, done, err, oe, out} taken after edge k.
  logic [5:0] s0 [32];
  logic [5:0] s1 [32];
  logic [5:0] s2 [32];

  int errors = 0;
  int checks = 0;

  localparam int B_RD = 5, B_WR = 4, B_DONE = 3, B_ERR = 2, B_OE = 1, B_OUT = 0;

  function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op,
                                     input logic [4:0] pa, input logic [4:0] ra,
                                     input logic [15:0] d);
    return {st, op, pa, ra, 2'b10, d};
  endfunction

  function automatic logic [31:0] col(input int d, input int b);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 32; k++) begin
      case (d)
        0:       v[k] = s0[k][b];
        1:       v[k] = s1[k][b];
        default: v[k] = s2[k][b];
      endcase
    end
    return v;
  endfunction

  function automatic logic [15:0] ser0();
    logic [15:0] v;
    v = '0;
    for (int k = 15; k <= 30; k++) v = {v[14:0], s0[k][B_OUT]};
    return v;
  endfunction

  task automatic send_ones(input int n);
    repeat (n) begin
      @(negedge mdc);
      mdio_in = 1'b1;
    end
  endtask

  task automatic frame(input int npre, input logic [31:0] f, input int nbits);
    for (int k = 0; k < 32; k++) begin
      s0[k] = '0; s1[k] = '0; s2[k] = '0;
    end
    send_ones(npre);
    for (int k = 0; k < nbits; k++) begin
      @(negedge mdc);
      mdio_in = f[31-k];
      @(posedge mdc);
      #1;
      s0[k] = {u0_rd_stb, u0_wr_stb, u0_done, u0_err, u0_oe, u0_out};
      s1[k] = {u1_rd_stb, u1_wr_stb, u1_done, u1_err, u1_oe, u1_out};
      s2[k] = {u2_rd_stb, u2_wr_stb, u2_done, u2_err, u2_oe, u2_out};
    end
  endtask

  task automatic test_reset();
    logic [5:0] ctl;
    repeat (3) @(posedge mdc);
    #1;
    ctl = {u0_rd_stb, u0_wr_stb, u0_done, u0_err, u0_oe, u0_out};
    checks++;
    if (ctl !== 6'b0) begin errors++; $display("FAIL reset_ctl: got %b expected 000000", ctl); end
    checks++;
    if ({u0_addr, u0_wr_data, u0_port} !== 22'b0) begin
      errors++; $display("FAIL reset_regs: got addr=%h wr_data=%h port=%h expected 0", u0_addr, u0_wr_data, u0_port);
    end
    checks++;
    if (u1_port !== 2'd0) begin errors++; $display("FAIL reset_port_u1: got %0d expected 0", u1_port); end
    @(negedge mdc);
    reset = 1'b0;
  endtask

  task automatic test_write();
    frame(32, mk(2'b01, 2'b01, 5'd1, 5'h0A, 16'h4546), 32);
    checks++;
    if (col(0, B_WR) !== 32'h8000_0000) begin errors++; $display("FAIL wr_stb_timing: got %h expected 80000000", col(0, B_WR)); end
    checks++;
    if (col(0, B_DONE) !== 32'h8000_0000) begin errors++; $display("FAIL wr_done_timing: got %h expected 80000000", col(0, B_DONE)); end
    checks++;
    if ((col(0, B_OE) | col(0, B_RD)) !== 32'h0) begin errors++; $display("FAIL wr_no_drive: got %h expected 0", col(0, B_OE) | col(0, B_RD)); end
    checks++;
    if (u0_wr_data !== 16'h4546) begin errors++; $display("FAIL wr_data: got %h expected 4546", u0_wr_data); end
    checks++;
    if (u0_addr !== 5'h0A) begin errors++; $display("FAIL wr_addr: got %h expected 0a", u0_addr); end
    checks++;
    if (u0_port !== 1'b0) begin errors++; $display("FAIL wr_port: got %h expected 0", u0_port); end
    checks++;
    if (col(1, B_WR) !== 32'h0) begin errors++; $display("FAIL wr_other_phy: got %h expected 0", col(1, B_WR)); end
  endtask

  task automatic test_read();
    frame(32, mk(2'b01, 2'b10, 5'd1, 5'd3, 16'hFFFF), 32);
    checks++;
    if (col(0, B_RD) !== 32'h0000_2000) begin errors++; $display("FAIL rd_stb_timing: got %h expected 00002000", col(0, B_RD)); end
    checks++;
    if (col(0, B_OE) !== 32'h7FFF_C000) begin errors++; $display("FAIL rd_oe_window: got %h expected 7fffc000", col(0, B_OE)); end
    checks++;
    if (ser0() !== 16'hA5C3) begin errors++; $display("FAIL rd_serial: got %h expected a5c3", ser0()); end
    checks++;
    if ((col(0, B_OUT) & 32'h8000_7FFF) !== 32'h0) begin
      errors++; $display("FAIL rd_out_idle: got %h expected 0", col(0, B_OUT) & 32'h8000_7FFF);
    end
    checks++;
    if (col(0, B_DONE) !== 32'h8000_0000) begin errors++; $display("FAIL rd_done: got %h expected 80000000", col(0, B_DONE)); end
    checks++;
    if (col(0, B_WR) !== 32'h0) begin errors++; $display("FAIL rd_no_wr: got %h expected 0", col(0, B_WR)); end
    checks++;
    if (u0_addr !== 5'd3) begin errors++; $display("FAIL rd_addr: got %h expected 03", u0_addr); end
  endtask

  task automatic test_multiport();
    frame(32, mk(2'b01, 2'b01, 5'd11, 5'd5, 16'h1234), 32);
    checks++;
    if (col(1, B_WR) !== 32'h8000_0000) begin errors++; $display("FAIL mp11_wr: got %h expected 80000000", col(1, B_WR)); end
    checks++;
    if (u1_port !== 2'd3) begin errors++; $display("FAIL mp11_port: got %0d expected 3", u1_port); end
    checks++;
    if (u1_wr_data !== 16'h1234) begin errors++; $display("FAIL mp11_data: got %h expected 1234", u1_wr_data); end
    frame(32, mk(2'b01, 2'b01, 5'd12, 5'd6, 16'h5678), 32);
    checks++;
    if ((col(1, B_WR) | col(1, B_DONE)) !== 32'h0) begin
      errors++; $display("FAIL mp12_ignored: got %h expected 0", col(1, B_WR) | col(1, B_DONE));
    end
    checks++;
    if (u1_port !== 2'd3 || u1_addr !== 5'd5) begin
      errors++; $display("FAIL mp12_hold: got port=%0d addr=%h expected port=3 addr=05", u1_port, u1_addr);
    end
    frame(32, mk(2'b01, 2'b01, 5'd9, 5'd7, 16'hBEEF), 32);
    checks++;
    if (col(1, B_WR) !== 32'h8000_0000) begin errors++; $display("FAIL mp9_wr: got %h expected 80000000", col(1, B_WR)); end
    checks++;
    if (u1_port !== 2'd1 || u1_wr_data !== 16'hBEEF) begin
      errors++; $display("FAIL mp9_vals: got port=%0d data=%h expected port=1 data=beef", u1_port, u1_wr_data);
    end
  endtask

  task automatic test_short_pre();
    frame(31, mk(2'b01, 2'b01, 5'd1, 5'd2, 16'h1111), 32);
    checks++;
    if ((col(0, B_WR) | col(0, B_DONE) | col(0, B_ERR)) !== 32'h0) begin
      errors++; $display("FAIL short_pre: got %h expected 0", col(0, B_WR) | col(0, B_DONE) | col(0, B_ERR));
    end
    checks++;
    if (u0_wr_data !== 16'h4546) begin errors++; $display("FAIL short_pre_data: got %h expected 4546", u0_wr_data); end
  endtask

  task automatic test_bad_frames();
    frame(32, mk(2'b01, 2'b11, 5'd1, 5'd5, 16'h0000), 32);
    checks++;
    if (col(0, B_ERR) !== 32'h0000_0008) begin errors++; $display("FAIL bad_op_err: got %h expected 00000008", col(0, B_ERR)); end
    checks++;
    if ((col(0, B_WR) | col(0, B_RD) | col(0, B_DONE) | col(0, B_OE)) !== 32'h0) begin
      errors++; $display("FAIL bad_op_quiet: got %h expected 0", col(0, B_WR) | col(0, B_RD) | col(0, B_DONE) | col(0, B_OE));
    end
    frame(32, mk(2'b00, 2'b01, 5'd1, 5'd5, 16'h0000), 32);
    checks++;
    if (col(0, B_ERR) !== 32'h0000_0002) begin errors++; $display("FAIL bad_st_err: got %h expected 00000002", col(0, B_ERR)); end
  endtask

  task automatic test_broadcast();
    frame(32, mk(2'b01, 2'b01, 5'd0, 5'd2, 16'h0F0F), 32);
    checks++;
    if (col(2, B_WR) !== 32'h8000_0000) begin errors++; $display("FAIL bc_wr: got %h expected 80000000", col(2, B_WR)); end
    checks++;
    if (u2_port !== 1'b0 || u2_wr_data !== 16'h0F0F || u2_addr !== 5'd2) begin
      errors++; $display("FAIL bc_vals: got port=%h data=%h addr=%h expected 0/0f0f/02", u2_port, u2_wr_data, u2_addr);
    end
    checks++;
    if (col(0, B_WR) !== 32'h0) begin errors++; $display("FAIL bc_no_bcast_u0: got %h expected 0", col(0, B_WR)); end
    frame(32, mk(2'b01, 2'b10, 5'd0, 5'd2, 16'hFFFF), 32);
    checks++;
    if ((col(2, B_RD) | col(2, B_OE) | col(2, B_DONE)) !== 32'h0) begin
      errors++; $display("FAIL bc_read_ignored: got %h expected 0", col(2, B_RD) | col(2, B_OE) | col(2, B_DONE));
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    frame(32, mk(2'b01, 2'b10, 5'd1, 5'd7, 16'hFFFF), 21);
    checks++;
    if (s0[20][B_OE] !== 1'b1) begin errors++; $display("FAIL mid_oe_before: got %b expected 1", s0[20][B_OE]); end
    reset = 1'b1;
    #1;
    checks++;
    if ({u0_oe, u0_out} !== 2'b00) begin errors++; $display("FAIL mid_oe_async: got %b expected 00", {u0_oe, u0_out}); end
    @(negedge mdc);
    reset = 1'b0;
    seen = 0;
    for (int k = 21; k < 32; k++) begin
      @(negedge mdc);
      mdio_in = 1'b1;
      @(posedge mdc);
      #1;
      if (u0_done || u0_rd_stb || u0_wr_stb || u0_oe) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mid_no_strobe: got %0d events expected 0", seen); end
    frame(32, mk(2'b01, 2'b10, 5'd1, 5'd4, 16'hFFFF), 32);
    checks++;
    if (col(0, B_DONE) !== 32'h8000_0000 || ser0() !== 16'hA5C3) begin
      errors++; $display("FAIL mid_recover: got done=%h data=%h expected 80000000/a5c3", col(0, B_DONE), ser0());
    end
    checks++;
    if (u0_addr !== 5'd4) begin errors++; $display("FAIL mid_recover_addr: got %h expected 04", u0_addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_multiport();
    test_short_pre();
    test_bad_frames();
    test_broadcast();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
